// File: rtl/jtframe_linebuf_draw.sv
// jtframe_linebuf_draw: fetches one 16-pixel 4bpp object row from ROM and streams it into a line buffer.
module jtframe_linebuf_draw #(
  parameter int AW = 9,
  parameter int PW = 4,
  parameter int RW = 20
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          draw,
  output logic          busy,
  input  logic [AW-1:0] xpos,
  input  logic          hflip,
  input  logic [PW-1:0] pal,
  input  logic [RW-2:0] addr,
  output logic [RW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [31:0]   rom_data,
  output logic [AW-1:0] wr_addr,
  output logic [PW+3:0] wr_data,
  output logic          we
);
  typedef enum logic [2:0] {IDLE, FETCH0, DRAW0, FETCH1, DRAW1} state_t;
  state_t        st_q, st_d;
  logic [AW-1:0] xpos_q, xpos_d, wr_addr_q, wr_addr_d;
  logic          hflip_q, hflip_d, busy_q, busy_d, rom_cs_q, rom_cs_d, we_q, we_d;
  logic [PW-1:0] pal_q, pal_d;
  logic [RW-2:0] addr_q, addr_d;
  logic [RW-1:0] rom_addr_q, rom_addr_d;
  logic [31:0]   data_q, data_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [PW+3:0] wr_data_q, wr_data_d;
  logic [3:0]    colour;
  always_comb begin
    st_d      = st_q;
    xpos_d    = xpos_q;
    hflip_d   = hflip_q;
    pal_d     = pal_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we_d      = 1'b0;
    colour    = hflip_q ? data_q[3:0] : data_q[31:28];
    unique case (st_q)
      IDLE: if (draw) begin
        xpos_d  = xpos;
        hflip_d = hflip;
        pal_d   = pal;
        addr_d  = addr;
        st_d    = FETCH0;
      end
      FETCH0, FETCH1: if (rom_ok) begin
        data_d = rom_data;
        cnt_d  = 3'd0;
        st_d   = st_q == FETCH0 ? DRAW0 : DRAW1;
      end
      DRAW0, DRAW1: begin
        // the latched word is shifted so the next pixel always sits at the edge selected by hflip
        we_d      = colour != 4'd0;
        wr_addr_d = xpos_q + AW'({st_q == DRAW1, cnt_q});
        wr_data_d = {pal_q, colour};
        data_d    = hflip_q ? {4'd0, data_q[31:4]} : {data_q[27:0], 4'd0};
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) st_d = st_q == DRAW0 ? FETCH1 : IDLE;
      end
      default: st_d = IDLE;
    endcase
    busy_d     = st_d != IDLE;
    rom_cs_d   = st_d == FETCH0 || st_d == FETCH1;
    rom_addr_d = rom_cs_d ? {addr_d, (st_d == FETCH1) ^ hflip_d} : rom_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      xpos_q     <= '0;
      hflip_q    <= 1'b0;
      pal_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      we_q       <= 1'b0;
    end else begin
      st_q       <= st_d;
      xpos_q     <= xpos_d;
      hflip_q    <= hflip_d;
      pal_q      <= pal_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      we_q       <= we_d;
    end
  end
  assign busy     = busy_q;
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign we       = we_q;
endmodule
